// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the seven-segment write controller.
//   - PS/2 scan codes that have editing meaning (keypad 4/6, backspace, ESC)
//   - printable ASCII window and the blank character used for erasing
//   - display digit count
//   - FSM state and arbitration grant enums
// ----------------------------------------------------------------------------
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] KB_KP_4 = 8'h6B;
  localparam logic [7:0] KB_KP_6 = 8'h74;
  localparam logic [7:0] KB_BKSP = 8'h66;
  localparam logic [7:0] KB_ESC  = 8'h76;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MIN   = 8'h20;
  localparam logic [7:0] ASCII_MAX   = 8'h7E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } seg7_state_e;

  typedef enum logic {
    KEY  = 1'b0,
    HOST = 1'b1
  } seg7_grant_e;

endpackage

// File: rtl/sync_rise_det.sv
// ----------------------------------------------------------------------------
// sync_rise_det
// Two-flop synchroniser for an asynchronous level followed by a rising-edge
// detector. The rise pulse is one clk wide and appears in the cycle after the
// second synchroniser flop first captures a 1.
//   clk       in  system clock
//   resetn    in  asynchronous active-low reset, all flops clear to 0
//   async_in  in  asynchronous input level
//   rise      out one-cycle pulse on a synchronised 0->1 transition
// ----------------------------------------------------------------------------
module sync_rise_det (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

// File: rtl/seg7_write_ctrl.sv
// ----------------------------------------------------------------------------
// seg7_write_ctrl
// Sequences every write into the 8-digit seven-segment character buffer and
// arbitrates between the PS/2 keyboard editor and a host requester. Owns the
// edit cursor (keypad navigation, auto-advance, backspace, clear-all).
//
// Ports:
//   clk          in  system clock
//   resetn       in  asynchronous active-low reset
//   key_new      in  new-key strobe from the keyboard (foreign clock domain)
//   key_code     in  PS/2 scan code, stable from key_new rise to next key
//   key_ascii    in  ASCII translation of key_code
//   host_req     in  host write request level
//   host_digit   in  host target digit
//   host_ascii   in  host character
//   host_ack     out one-cycle grant/complete pulse to the host
//   wr_en        out one-cycle display write strobe
//   wr_idx       out digit index of the write
//   wr_ascii     out character of the write
//   cursor       out current edit cursor
//   key_overrun  out one-cycle pulse when a key is dropped
//   fsm_state    out current FSM state (observability)
//
// Build option: define SEG7_CURSOR_WRAP_EN to make every cursor move wrap
// modulo NUM_DIGITS instead of saturating at the ends.
//
// Host handshake: host_req is a level held together with host_digit and
// host_ascii. The request is taken in an IDLE cycle N; in cycle N+1 the write
// strobe and host_ack are high together, which completes the transfer. The
// host must have released host_req by cycle N+2, when arbitration resumes.
// ----------------------------------------------------------------------------
module seg7_write_ctrl #(
  parameter  int NUM_DIGITS = seg7_pkg::NUM_DIGITS,
  parameter  int CUR_RESET  = NUM_DIGITS - 1,
  localparam int CW         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  key_new,
  input  logic [7:0]            key_code,
  input  logic [7:0]            key_ascii,
  input  logic                  host_req,
  input  logic [CW-1:0]         host_digit,
  input  logic [7:0]            host_ascii,
  output logic                  host_ack,
  output logic                  wr_en,
  output logic [CW-1:0]         wr_idx,
  output logic [7:0]            wr_ascii,
  output logic [CW-1:0]         cursor,
  output logic                  key_overrun,
  output seg7_pkg::seg7_state_e fsm_state
);

  import seg7_pkg::*;

  localparam logic [CW-1:0] CUR_MAX  = CW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CUR_INIT = CW'(CUR_RESET);

  function automatic logic [CW-1:0] cur_up(input logic [CW-1:0] c);
`ifdef SEG7_CURSOR_WRAP_EN
    return (c == CUR_MAX) ? '0 : c + 1'b1;
`else
    return (c == CUR_MAX) ? c : c + 1'b1;
`endif
  endfunction

  function automatic logic [CW-1:0] cur_down(input logic [CW-1:0] c);
`ifdef SEG7_CURSOR_WRAP_EN
    return (c == '0) ? CUR_MAX : c - 1'b1;
`else
    return (c == '0) ? c : c - 1'b1;
`endif
  endfunction

  logic        key_rise;
  logic        key_pend;
  logic [7:0]  key_code_q;
  logic [7:0]  key_ascii_q;
  seg7_grant_e last_grant;
  logic        grant_key;
  logic        grant_host;
  logic        key_printable;

  sync_rise_det u_key_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (key_new),
    .rise     (key_rise)
  );

  // Round robin: when both sides are waiting, whoever was not served last wins.
  // last_grant resets to HOST so the keyboard wins the first contest.
  assign grant_key  = (fsm_state == IDLE) && key_pend &&
                      (!host_req || (last_grant == HOST));
  assign grant_host = (fsm_state == IDLE) && host_req && !grant_key;

  assign key_printable = (key_ascii_q >= ASCII_MIN) && (key_ascii_q <= ASCII_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_state   <= IDLE;
      wr_en       <= 1'b0;
      wr_idx      <= '0;
      wr_ascii    <= ASCII_SPACE;
      host_ack    <= 1'b0;
      key_overrun <= 1'b0;
      cursor      <= CUR_INIT;
      key_pend    <= 1'b0;
      key_code_q  <= 8'h00;
      key_ascii_q <= 8'h00;
      last_grant  <= HOST;
    end else begin
      wr_en       <= 1'b0;
      host_ack    <= 1'b0;
      key_overrun <= 1'b0;

      // A key edge arriving on the very edge that consumes the pending key is
      // accepted; only an edge that meets a still-held key is dropped.
      if (key_rise) begin
        if (key_pend && !grant_key) begin
          key_overrun <= 1'b1;
        end else begin
          key_pend    <= 1'b1;
          key_code_q  <= key_code;
          key_ascii_q <= key_ascii;
        end
      end else if (grant_key) begin
        key_pend <= 1'b0;
      end

      case (fsm_state)
        IDLE: begin
          if (grant_key) begin
            last_grant <= KEY;
            if (key_code_q == KB_KP_4) begin
              cursor <= cur_up(cursor);
            end else if (key_code_q == KB_KP_6) begin
              cursor <= cur_down(cursor);
            end else if (key_code_q == KB_BKSP) begin
              wr_en     <= 1'b1;
              wr_idx    <= cursor;
              wr_ascii  <= ASCII_SPACE;
              cursor    <= cur_up(cursor);
              fsm_state <= WRITE;
            end else if (key_code_q == KB_ESC) begin
              // First clear write goes out with the grant; CLEAR walks down to 0.
              wr_en     <= 1'b1;
              wr_idx    <= CUR_MAX;
              wr_ascii  <= ASCII_SPACE;
              cursor    <= CUR_INIT;
              fsm_state <= CLEAR;
            end else if (key_printable) begin
              wr_en     <= 1'b1;
              wr_idx    <= cursor;
              wr_ascii  <= key_ascii_q;
              cursor    <= cur_down(cursor);
              fsm_state <= WRITE;
            end
          end else if (grant_host) begin
            last_grant <= HOST;
            wr_en      <= 1'b1;
            wr_idx     <= host_digit;
            wr_ascii   <= host_ascii;
            host_ack   <= 1'b1;
            fsm_state  <= WRITE;
          end
        end
        WRITE: begin
          fsm_state <= IDLE;
        end
        CLEAR: begin
          if (wr_idx == '0) begin
            fsm_state <= IDLE;
          end else begin
            wr_en  <= 1'b1;
            wr_idx <= wr_idx - 1'b1;
          end
        end
        default: begin
          fsm_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_write_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg7_write_ctrl
// Bench for seg7_write_ctrl. Each scenario task drives keys/host requests,
// pushes the writes it expects ({host_ack, wr_idx, wr_ascii}) onto exp_q and
// checks cursor/handshake results inline. A negedge monitor pops exp_q on
// every wr_en and flags any write that was not expected.
// Define SEG7_CURSOR_WRAP_EN for both bench and RTL to check the wrap build.
// ----------------------------------------------------------------------------
module tb_seg7_write_ctrl;

  import seg7_pkg::*;

  localparam int W = 12;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        key_new = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic [7:0]  key_ascii = 8'h00;
  logic        host_req = 1'b0;
  logic [2:0]  host_digit = 3'd0;
  logic [7:0]  host_ascii = 8'h00;
  logic        host_ack;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [7:0]  wr_ascii;
  logic [2:0]  cursor;
  logic        key_overrun;
  seg7_state_e fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_ovr = 0;
  int cyc   = 0;
  int exp_cur;

  logic [W-1:0] exp_q[$];
  int           wr_cyc_q[$];

  seg7_write_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_new     (key_new),
    .key_code    (key_code),
    .key_ascii   (key_ascii),
    .host_req    (host_req),
    .host_digit  (host_digit),
    .host_ascii  (host_ascii),
    .host_ack    (host_ack),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_ascii    (wr_ascii),
    .cursor      (cursor),
    .key_overrun (key_overrun),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- cursor model ----------------
  function automatic int m_up(input int c);
`ifdef SEG7_CURSOR_WRAP_EN
    return (c == 7) ? 0 : c + 1;
`else
    return (c == 7) ? 7 : c + 1;
`endif
  endfunction

  function automatic int m_down(input int c);
`ifdef SEG7_CURSOR_WRAP_EN
    return (c == 0) ? 7 : c - 1;
`else
    return (c == 0) ? 0 : c - 1;
`endif
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (resetn) begin
      if (key_overrun) n_ovr++;
      if (host_ack && !wr_en) begin
        n_cmp++;
        n_err++;
        $display("FAIL ack_without_write got=host_ack=1,wr_en=0 exp=wr_en=1");
      end
      if (wr_en) begin
        got = {host_ack, wr_idx, wr_ascii};
        wr_cyc_q.push_back(cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write got=%03h exp=none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL write_data got=%03h exp=%03h", got, exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    resetn = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic press_key(input logic [7:0] code, input logic [7:0] ascii,
                           input int hi, input int lo);
    key_code  = code;
    key_ascii = ascii;
    key_new   = 1'b1;
    repeat (hi) @(posedge clk);
    #1 key_new = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] d, input logic [7:0] a, output bit got);
    host_digit = d;
    host_ascii = a;
    host_req   = 1'b1;
    got        = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (host_ack) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 host_req = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%0h exp=0", wr_en); end
    n_cmp++; if (wr_idx !== 3'd0) begin n_err++; $display("FAIL reset_wr_idx got=%0h exp=0", wr_idx); end
    n_cmp++; if (wr_ascii !== 8'h20) begin n_err++; $display("FAIL reset_wr_ascii got=%0h exp=20", wr_ascii); end
    n_cmp++; if (host_ack !== 1'b0) begin n_err++; $display("FAIL reset_host_ack got=%0h exp=0", host_ack); end
    n_cmp++; if (key_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%0h exp=0", key_overrun); end
    n_cmp++; if (cursor !== 3'd7) begin n_err++; $display("FAIL reset_cursor got=%0d exp=7", cursor); end
    n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, IDLE); end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    exp_cur = 7;
  endtask

  task automatic test_key_write();
    bit ok;
    exp_q.push_back({1'b0, 3'd7, 8'h41});
    press_key(8'h1C, 8'h41, 3, 3);
    drain(ok);
    exp_cur = 6;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL key_write_done got=pending exp=written"); end
    n_cmp++; if (cursor !== 3'(exp_cur)) begin n_err++; $display("FAIL key_write_cursor got=%0d exp=%0d", cursor, exp_cur); end
  endtask

  task automatic test_cursor_limits();
    bit ok;
    repeat (6) begin
      press_key(KB_KP_6, 8'h36, 3, 3);
      exp_cur = m_down(exp_cur);
    end
    n_cmp++; if (cursor !== 3'd0) begin n_err++; $display("FAIL nav_to_zero got=%0d exp=0", cursor); end
    press_key(KB_KP_6, 8'h36, 3, 3);
    exp_cur = m_down(exp_cur);
    n_cmp++; if (cursor !== 3'(exp_cur)) begin n_err++; $display("FAIL kp6_at_zero got=%0d exp=%0d", cursor, exp_cur); end
    exp_q.push_back({1'b0, 3'(exp_cur), 8'h42});
    press_key(8'h32, 8'h42, 3, 3);
    exp_cur = m_down(exp_cur);
    drain(ok);
    n_cmp++; if (!ok || cursor !== 3'(exp_cur)) begin n_err++; $display("FAIL write_at_edge got=%0d/%0d exp=%0d/1", cursor, ok, exp_cur); end
    exp_q.push_back({1'b0, 3'(exp_cur), 8'h20});
    press_key(KB_BKSP, 8'h08, 3, 3);
    exp_cur = m_up(exp_cur);
    drain(ok);
    n_cmp++; if (!ok || cursor !== 3'(exp_cur)) begin n_err++; $display("FAIL backspace got=%0d/%0d exp=%0d/1", cursor, ok, exp_cur); end
    // Non-printable, non-editing key: no write, cursor untouched.
    press_key(8'h05, 8'h7F, 3, 3);
    drain(ok);
    n_cmp++; if (cursor !== 3'(exp_cur)) begin n_err++; $display("FAIL ignored_key got=%0d exp=%0d", cursor, exp_cur); end
    // Top of the printable window is still written.
    exp_q.push_back({1'b0, 3'(exp_cur), 8'h7E});
    press_key(8'h0E, 8'h7E, 3, 3);
    exp_cur = m_down(exp_cur);
    drain(ok);
    n_cmp++; if (!ok || cursor !== 3'(exp_cur)) begin n_err++; $display("FAIL ascii_max got=%0d/%0d exp=%0d/1", cursor, ok, exp_cur); end
    for (int i = 0; i < 8; i++) begin
      if (exp_cur != 7) begin
        press_key(KB_KP_4, 8'h34, 3, 3);
        exp_cur = m_up(exp_cur);
      end
    end
    press_key(KB_KP_4, 8'h34, 3, 3);
    exp_cur = m_up(exp_cur);
    n_cmp++; if (cursor !== 3'(exp_cur)) begin n_err++; $display("FAIL kp4_at_max got=%0d exp=%0d", cursor, exp_cur); end
  endtask

  task automatic test_arbitration();
    bit ok;
    bit acked;
    int gap;
    do_reset();
    exp_cur = 7;
    wr_cyc_q.delete();
    exp_q.push_back({1'b0, 3'd7, 8'h43});
    exp_q.push_back({1'b1, 3'd3, 8'h35});
    fork
      press_key(8'h21, 8'h43, 3, 3);
      begin
        repeat (3) @(posedge clk);
        #1 host_write(3'd3, 8'h35, acked);
      end
    join
    drain(ok);
    exp_cur = 6;
    gap = (wr_cyc_q.size() == 2) ? wr_cyc_q[1] - wr_cyc_q[0] : -1;
    n_cmp++; if (!acked) begin n_err++; $display("FAIL arb_host_ack got=none exp=ack"); end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL arb_done got=pending exp=written"); end
    n_cmp++; if (gap != 2) begin n_err++; $display("FAIL arb_gap got=%0d exp=2", gap); end
    n_cmp++; if (cursor !== 3'(exp_cur)) begin n_err++; $display("FAIL arb_cursor got=%0d exp=%0d", cursor, exp_cur); end
  endtask

  task automatic test_clear();
    bit ok;
    bit acked;
    bit consec;
    repeat (4) press_key(KB_KP_6, 8'h36, 3, 3);
    n_cmp++; if (cursor !== 3'd2) begin n_err++; $display("FAIL pre_clear_cursor got=%0d exp=2", cursor); end
    wr_cyc_q.delete();
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, 3'(i), 8'h20});
    exp_q.push_back({1'b1, 3'd5, 8'h39});
    fork
      press_key(KB_ESC, 8'h1B, 3, 3);
      begin
        repeat (4) @(posedge clk);
        #1 host_write(3'd5, 8'h39, acked);
      end
    join
    drain(ok);
    exp_cur = 7;
    consec = (wr_cyc_q.size() == 9);
    for (int i = 0; i < 7; i++) begin
      if (consec && (wr_cyc_q[i+1] - wr_cyc_q[i] != 1)) consec = 1'b0;
    end
    n_cmp++; if (!ok || !acked) begin n_err++; $display("FAIL clear_done got=%0d/%0d exp=1/1", ok, acked); end
    n_cmp++; if (!consec) begin n_err++; $display("FAIL clear_consecutive got=%0d writes exp=9 with 8 back-to-back", wr_cyc_q.size()); end
    n_cmp++; if (cursor !== 3'd7) begin n_err++; $display("FAIL clear_cursor got=%0d exp=7", cursor); end
  endtask

  task automatic test_overrun();
    bit ok;
    int ovr0;
    ovr0 = n_ovr;
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, 3'(i), 8'h20});
    exp_q.push_back({1'b0, 3'd7, 8'h44});
    // 'D' becomes pending during the clear sweep; 'E' arrives while it waits.
    press_key(KB_ESC, 8'h1B, 2, 2);
    press_key(8'h23, 8'h44, 2, 2);
    press_key(8'h24, 8'h45, 2, 2);
    drain(ok);
    repeat (10) @(posedge clk);
    #1;
    exp_cur = 6;
    n_cmp++; if (n_ovr - ovr0 != 1) begin n_err++; $display("FAIL overrun_pulses got=%0d exp=1", n_ovr - ovr0); end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL overrun_first_key got=pending exp=written"); end
    n_cmp++; if (cursor !== 3'(exp_cur)) begin n_err++; $display("FAIL overrun_cursor got=%0d exp=%0d", cursor, exp_cur); end
  endtask

  task automatic test_reset_mid_clear();
    bit ok;
    bit found;
    int nwr;
    exp_q.push_back({1'b0, 3'd6, 8'h46});
    press_key(8'h2B, 8'h46, 3, 3);
    drain(ok);
    n_cmp++; if (!ok || cursor !== 3'd5) begin n_err++; $display("FAIL pre_reset_write got=%0d/%0d exp=5/1", cursor, ok); end
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, 3'(i), 8'h20});
    found = 1'b0;
    fork
      press_key(KB_ESC, 8'h1B, 3, 3);
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (wr_en && wr_idx == 3'd4) begin
            found = 1'b1;
            break;
          end
        end
        #1 resetn = 1'b0;
        #1;
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL mid_clear_wr_en got=%0h exp=0", wr_en); end
        n_cmp++; if (cursor !== 3'd7) begin n_err++; $display("FAIL mid_clear_cursor got=%0d exp=7", cursor); end
        n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL mid_clear_state got=%0d exp=%0d", fsm_state, IDLE); end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
      end
    join
    n_cmp++; if (!found) begin n_err++; $display("FAIL mid_clear_reached got=not_seen exp=idx4"); end
    nwr = wr_cyc_q.size();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (wr_cyc_q.size() != nwr) begin n_err++; $display("FAIL no_write_after_release got=%0d exp=0", wr_cyc_q.size() - nwr); end
    n_cmp++; if (cursor !== 3'd7) begin n_err++; $display("FAIL post_release_cursor got=%0d exp=7", cursor); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_key_write();
    test_cursor_limits();
    test_arbitration();
    test_clear();
    test_overrun();
    test_reset_mid_clear();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
